// File: rtl/fifo_status.sv
// rtl/fifo_status.sv - single-clock FIFO with registered flags, level and fall-through head
module fifo_status #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AFULL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_shift,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       out_pop,
    output logic                       out_nempty,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [LW-1:0]    level_next;
    logic             write_acc;
    logic             pop_acc;
    logic             head_load;
    logic             head_bypass;

    always_comb begin
        write_acc   = in_shift & in_ready;
        pop_acc     = out_pop & out_nempty;
        level_next  = level + LW'(write_acc) - LW'(pop_acc);
        rd_ptr_next = rd_ptr + AW'(pop_acc);
        head_load   = 1'b0;
        head_bypass = 1'b0;
        // The head register mirrors mem[rd_ptr]; a fresh write that becomes the head skips the array.
        if (pop_acc) begin
            if (level >= LW'(2)) begin
                head_load = 1'b1;
            end else if (write_acc) begin
                head_bypass = 1'b1;
            end
        end else if (level == '0 && write_acc) begin
            head_bypass = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (write_acc && !clear) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            in_ready    <= 1'b1;
            out_nempty  <= 1'b0;
            out_data    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            in_ready    <= 1'b1;
            out_nempty  <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + AW'(write_acc);
            rd_ptr      <= rd_ptr_next;
            level       <= level_next;
            in_ready    <= (level_next != LW'(DEPTH));
            out_nempty  <= (level_next != '0);
            almost_full <= (level_next >= LW'(AFULL));
            if (in_shift && !in_ready) begin
                overflow <= 1'b1;
            end
            if (out_pop && !out_nempty) begin
                underflow <= 1'b1;
            end
            if (head_load) begin
                out_data <= mem[rd_ptr_next];
            end else if (head_bypass) begin
                out_data <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_status.sv
// tb/tb_fifo_status.sv - self-checking bench for fifo_status (vectors, directed sequences, random vs queue model)
module tb_fifo_status;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_shift = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_pop = 1'b0;
    logic             out_nempty;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       level;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] q[$];
    bit               m_ovf = 0;
    bit               m_unf = 0;

    fifo_status #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_shift(in_shift), .in_data(in_data), .in_ready(in_ready),
        .out_pop(out_pop), .out_nempty(out_nempty), .out_data(out_data),
        .level(level), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":level"}, int'(level), q.size());
        chk({tag, ":in_ready"}, int'(in_ready), int'(q.size() != DEPTH));
        chk({tag, ":out_nempty"}, int'(out_nempty), int'(q.size() != 0));
        chk({tag, ":almost_full"}, int'(almost_full), int'(q.size() >= AFULL));
        chk({tag, ":overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ":underflow"}, int'(underflow), int'(m_unf));
        if (q.size() != 0) chk({tag, ":out_data"}, int'(out_data), int'(q[0]));
    endtask

    // Drive one cycle, advance the queue model by the operation rules, compare after the edge.
    task automatic step(input bit sh, input bit pp, input bit cl, input logic [WIDTH-1:0] d, input string tag);
        bit wa, pa;
        in_shift = sh; out_pop = pp; clear = cl; in_data = d;
        @(posedge clk);
        if (cl) begin
            q.delete(); m_ovf = 0; m_unf = 0;
        end else begin
            wa = sh && (q.size() < DEPTH);
            pa = pp && (q.size() > 0);
            if (sh && !wa) m_ovf = 1;
            if (pp && !pa) m_unf = 1;
            if (pa) void'(q.pop_front());
            if (wa) q.push_back(d);
        end
        #1;
        in_shift = 0; out_pop = 0; clear = 0;
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ":level"}, int'(level), 0);
        chk({tag, ":in_ready"}, int'(in_ready), 1);
        chk({tag, ":out_nempty"}, int'(out_nempty), 0);
        chk({tag, ":out_data"}, int'(out_data), 0);
        chk({tag, ":almost_full"}, int'(almost_full), 0);
        chk({tag, ":overflow"}, int'(overflow), 0);
        chk({tag, ":underflow"}, int'(underflow), 0);
    endtask

    typedef struct {
        bit               sh;
        bit               pp;
        bit               cl;
        logic [WIDTH-1:0] din;
        int               exp_level;
        bit               exp_nempty;
        bit               exp_unf;
        logic [WIDTH-1:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 0, 0, 8'h5A, 1, 1, 0, 8'h5A};
        vecs[1] = '{1, 1, 0, 8'h5B, 1, 1, 0, 8'h5B};
        vecs[2] = '{1, 0, 0, 8'h5C, 2, 1, 0, 8'h5B};
        vecs[3] = '{0, 1, 0, 8'h00, 1, 1, 0, 8'h5C};
        vecs[4] = '{0, 1, 0, 8'h00, 0, 0, 0, 8'h00};
        vecs[5] = '{0, 1, 0, 8'h00, 0, 0, 1, 8'h00};
        vecs[6] = '{1, 0, 1, 8'h11, 0, 0, 0, 8'h00};
        vecs[7] = '{1, 0, 0, 8'h22, 1, 1, 0, 8'h22};

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill with 0x01..0x10, then one overflowing write
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, 0, 8'(i), "fill");
            if (i == AFULL - 1) chk("afull_before_14", int'(almost_full), 0);
            if (i == AFULL) chk("afull_at_14", int'(almost_full), 1);
            if (i == DEPTH - 1) chk("ready_at_15", int'(in_ready), 1);
        end
        chk("ready_full", int'(in_ready), 0);
        chk("level_full", int'(level), DEPTH);
        step(1, 0, 0, 8'hAA, "over");
        chk("overflow_set", int'(overflow), 1);

        // Drain in order; 0xAA must never appear
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_data", int'(out_data), i);
            step(0, 1, 0, 8'h00, "drain");
        end
        chk("drained_nempty", int'(out_nempty), 0);
        step(0, 1, 0, 8'h00, "under");
        chk("underflow_set", int'(underflow), 1);
        chk("under_level", int'(level), 0);

        step(0, 0, 1, 8'h00, "clr0");
        foreach (vecs[i]) begin
            step(vecs[i].sh, vecs[i].pp, vecs[i].cl, vecs[i].din, "vec");
            chk("vec_level", int'(level), vecs[i].exp_level);
            chk("vec_nempty", int'(out_nempty), int'(vecs[i].exp_nempty));
            chk("vec_unf", int'(underflow), int'(vecs[i].exp_unf));
            if (vecs[i].exp_nempty) chk("vec_data", int'(out_data), int'(vecs[i].exp_data));
        end

        // Streaming at level 3 across several pointer wraps
        step(0, 0, 1, 8'h00, "clr1");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(i), "pre");
        for (int i = 3; i < 103; i++) begin
            step(1, 1, 0, 8'(i), "stream");
            chk("stream_level", int'(level), 3);
            chk("stream_head", int'(out_data), (i - 2) & 8'hFF);
        end

        // Full FIFO: simultaneous write and pop drops the write
        step(0, 0, 1, 8'h00, "clr2");
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 8'(8'h40 + i), "fill2");
        step(1, 1, 0, 8'hEE, "full_wp");
        chk("full_wp_level", int'(level), DEPTH - 1);
        chk("full_wp_ovf", int'(overflow), 1);
        step(1, 0, 1, 8'hEF, "clr_shift");
        chk("clr_level", int'(level), 0);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_nempty", int'(out_nempty), 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h90 + i), "prereset");
        #3 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        q.delete(); m_ovf = 0; m_unf = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1, 0, 0, 8'h77, "post_reset");
        chk("post_reset_data", int'(out_data), 8'h77);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0 ? 0 : 1) ^ 1'(i[6]),
                 ($urandom_range(0, 40) == 0), 8'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
